// File: rtl/decoder_pipe_n_to_m_if.sv
// Stream bundle between the command front-end and the index decoder.
// Latency: none (wiring only).
// Backpressure: carries valid/ready on both the request and decoded-word sides.
interface decoder_pipe_n_to_m_if #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 8,
  parameter int CNT_W = 8
);
  logic             valid_i;
  logic             ready_o;
  logic [IN_W-1:0]  d_i;
  logic [1:0]       mode_i;
  logic             valid_o;
  logic             ready_i;
  logic [OUT_W-1:0] y_o;
  logic             err_o;
  logic [CNT_W-1:0] err_cnt_o;

  // Driver side: issues requests and accepts decoded words.
  modport master (
    output valid_i, d_i, mode_i, ready_i,
    input  ready_o, valid_o, y_o, err_o, err_cnt_o
  );

  // Decoder side.
  modport slave (
    input  valid_i, d_i, mode_i, ready_i,
    output ready_o, valid_o, y_o, err_o, err_cnt_o
  );
endinterface

// File: rtl/decoder_pipe_n_to_m.sv
// Registered N-to-M index decoder (one-hot, thermometer, active-low one-hot) with error flag/count.
// Latency: one cycle from accept to y_o when the output register is empty or draining.
// Backpressure: 2-entry skid (output + skid register); registered ready_o drops only when the skid is full.
module decoder_pipe_n_to_m #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 8,
  parameter int CNT_W = 8
) (
  input logic                 clk_i,
  input logic                 rst_i,
  decoder_pipe_n_to_m_if.slave bus
);

  // Reject parameter combinations the decode cannot represent.
  generate
    if (IN_W < 1 || IN_W > 8 || OUT_W < 2 || OUT_W > (1 << IN_W)) begin : g_bad_params
      $error("decoder_pipe_n_to_m: IN_W must be 1..8 and OUT_W 2..2**IN_W");
    end
  endgenerate

  typedef struct packed {
    logic             err;
    logic [OUT_W-1:0] y;
  } word_t;

  word_t            out_q;
  word_t            skid_q;
  word_t            new_word;
  logic             out_vld;
  logic             skid_vld;
  logic             rdy_q;
  logic [CNT_W-1:0] err_cnt;
  logic [OUT_W-1:0] onehot;
  logic [OUT_W-1:0] therm;
  logic             in_range;
  logic             accept;
  int               idx;

  assign accept = bus.valid_i & rdy_q;

  // Decode the incoming request into its output word and error sideband.
  always_comb begin
    idx      = int'(bus.d_i);
    in_range = (idx < OUT_W);
    onehot   = '0;
    therm    = '0;
    new_word = '0;
    for (int k = 0; k < OUT_W; k++) begin
      onehot[k] = (k == idx);
      therm[k]  = (k <= idx);
    end
    case (bus.mode_i)
      2'b00: begin
        new_word.y   = onehot;
        new_word.err = ~in_range;
      end
      2'b01: begin
        // k <= idx would saturate to all ones past the top; out-of-range must read as zero.
        new_word.y   = in_range ? therm : '0;
        new_word.err = ~in_range;
      end
      2'b10: begin
        // onehot is zero when out of range, so its inverse is the required all-ones word.
        new_word.y   = ~onehot;
        new_word.err = ~in_range;
      end
      default: begin
        new_word.y   = '0;
        new_word.err = 1'b1;
      end
    endcase
  end

  // Output/skid registers, registered ready and saturating error counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q    <= '0;
      out_vld  <= 1'b0;
      skid_q   <= '0;
      skid_vld <= 1'b0;
      rdy_q    <= 1'b1;
      err_cnt  <= '0;
    end else begin
      if (!out_vld || bus.ready_i) begin
        // Output register is free this edge: the skid word has priority to keep FIFO order.
        if (skid_vld) begin
          out_q    <= skid_q;
          out_vld  <= 1'b1;
          skid_vld <= 1'b0;
          rdy_q    <= 1'b1;
        end else if (accept) begin
          out_q   <= new_word;
          out_vld <= 1'b1;
        end else begin
          out_vld <= 1'b0;
        end
      end else if (accept) begin
        // Stalled output: park the word and close the input until the skid drains.
        skid_q   <= new_word;
        skid_vld <= 1'b1;
        rdy_q    <= 1'b0;
      end
      if (accept && new_word.err && (err_cnt != {CNT_W{1'b1}})) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.ready_o   = rdy_q;
  assign bus.valid_o   = out_vld;
  assign bus.y_o       = out_q.y;
  assign bus.err_o     = out_q.err;
  assign bus.err_cnt_o = err_cnt;

endmodule

// File: tb/tb_decoder_pipe_n_to_m.sv
// Bench for decoder_pipe_n_to_m: directed steps plus random traffic against a word-queue model.
// Latency: checks every cycle, one cycle after each clock edge.
// Backpressure: model treats the block as a 2-deep FIFO of decoded words.
module tb_decoder_pipe_n_to_m;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  decoder_pipe_n_to_m_if #(.IN_W(3), .OUT_W(8), .CNT_W(8)) a_if ();
  decoder_pipe_n_to_m_if #(.IN_W(3), .OUT_W(6), .CNT_W(2)) b_if ();

  decoder_pipe_n_to_m #(.IN_W(3), .OUT_W(8), .CNT_W(8)) dut_a (
    .clk_i (clk),
    .rst_i (rst_a),
    .bus   (a_if.slave)
  );

  decoder_pipe_n_to_m #(.IN_W(3), .OUT_W(6), .CNT_W(2)) dut_b (
    .clk_i (clk),
    .rst_i (rst_b),
    .bus   (b_if.slave)
  );

  int checks = 0;
  int errors = 0;
  int q[$];      // words held inside dut_a, oldest first: {err, y[15:0]}
  int cnt_a = 0;

  // Expected {err, y} for one request, straight from the decode rules.
  function automatic int ref_dec(int ow, int idx, int mode);
    int mask = (1 << ow) - 1;
    int y;
    int err;
    if (mode == 3) begin
      y = 0;
      err = 1;
    end else if (idx >= ow) begin
      err = 1;
      y = (mode == 2) ? mask : 0;
    end else begin
      err = 0;
      case (mode)
        0:       y = 1 << idx;
        1:       y = (1 << (idx + 1)) - 1;
        default: y = mask & ~(1 << idx);
      endcase
    end
    return (err << 16) | y;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_a(input bit v, input int d, input int m);
    a_if.valid_i = v;
    a_if.d_i     = d[2:0];
    a_if.mode_i  = m[1:0];
  endtask

  task automatic drive_b(input bit v, input int d, input int m);
    b_if.valid_i = v;
    b_if.d_i     = d[2:0];
    b_if.mode_i  = m[1:0];
  endtask

  // Advance one clock; update the dut_a model from pre-edge inputs, then check dut_a.
  task automatic tick();
    bit xfer;
    bit acc;
    int e;
    if (rst_a) begin
      q.delete();
      cnt_a = 0;
    end else begin
      xfer = (q.size() > 0) && a_if.ready_i;
      acc  = a_if.valid_i && (q.size() < 2);
      if (xfer) void'(q.pop_front());
      if (acc) begin
        e = ref_dec(8, int'(a_if.d_i), int'(a_if.mode_i));
        q.push_back(e);
        if (((e >> 16) & 1) == 1 && cnt_a < 255) cnt_a++;
      end
    end
    @(posedge clk);
    #1;
    chk("a_valid", a_if.valid_o, q.size() > 0);
    chk("a_ready", a_if.ready_o, q.size() < 2);
    chk("a_cnt", a_if.err_cnt_o, cnt_a);
    if (q.size() > 0) begin
      chk("a_y", a_if.y_o, q[0] & 32'hffff);
      chk("a_err", a_if.err_o, (q[0] >> 16) & 1);
    end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    drive_a(1'b1, 5, 0);
    drive_b(1'b1, 5, 0);
    a_if.ready_i = 1'b1;
    b_if.ready_i = 1'b1;
    tick();
    chk("rst_a_y", a_if.y_o, 0);
    chk("rst_a_err", a_if.err_o, 0);
    chk("rst_b_valid", b_if.valid_o, 0);
    chk("rst_b_ready", b_if.ready_o, 1);
    chk("rst_b_cnt", b_if.err_cnt_o, 0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    drive_b(1'b0, 0, 0);

    // One-hot sweep at full rate.
    for (int i = 0; i < 8; i++) begin
      drive_a(1'b1, i, 0);
      tick();
      chk("sweep_y", a_if.y_o, 1 << i);
      chk("sweep_vld", a_if.valid_o, 1);
      chk("sweep_err", a_if.err_o, 0);
    end

    // Same index through the remaining modes.
    drive_a(1'b1, 3, 1);
    tick();
    chk("therm_y", a_if.y_o, 8'h0f);
    drive_a(1'b1, 3, 2);
    tick();
    chk("aloh_y", a_if.y_o, 8'hf7);
    chk("aloh_err", a_if.err_o, 0);
    drive_a(1'b1, 3, 3);
    tick();
    chk("ill_y", a_if.y_o, 8'h00);
    chk("ill_err", a_if.err_o, 1);
    chk("ill_cnt", a_if.err_cnt_o, 1);
    drive_a(1'b0, 0, 0);
    tick();

    // Backpressure: fill output and skid, then release.
    a_if.ready_i = 1'b0;
    drive_a(1'b1, 1, 0);
    tick();
    drive_a(1'b1, 2, 0);
    tick();
    chk("bp_y_hold", a_if.y_o, 8'h02);
    chk("bp_rdy_low", a_if.ready_o, 0);
    drive_a(1'b0, 0, 0);
    tick();
    chk("bp_y_stable", a_if.y_o, 8'h02);
    a_if.ready_i = 1'b1;
    tick();
    chk("bp_y_next", a_if.y_o, 8'h04);
    chk("bp_rdy_back", a_if.ready_o, 1);
    tick();
    chk("bp_drained", a_if.valid_o, 0);

    // Reset while both entries are held.
    a_if.ready_i = 1'b0;
    drive_a(1'b1, 5, 0);
    tick();
    drive_a(1'b1, 6, 1);
    tick();
    chk("mr_full", a_if.ready_o, 0);
    drive_a(1'b0, 0, 0);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    chk("mr_valid", a_if.valid_o, 0);
    chk("mr_ready", a_if.ready_o, 1);
    chk("mr_y", a_if.y_o, 0);
    chk("mr_cnt", a_if.err_cnt_o, 0);
    a_if.ready_i = 1'b1;
    tick();
    tick();
    chk("mr_no_stale", a_if.valid_o, 0);

    // Random traffic and stalls against the queue model.
    for (int n = 0; n < 400; n++) begin
      drive_a($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
      a_if.ready_i = ($urandom_range(0, 2) != 0);
      tick();
    end
    drive_a(1'b0, 0, 0);
    a_if.ready_i = 1'b1;
    tick();
    tick();
    tick();

    // Narrow output: out-of-range handling.
    drive_b(1'b1, 6, 0);
    tick();
    chk("oor_y", b_if.y_o, 6'h00);
    chk("oor_err", b_if.err_o, 1);
    chk("oor_cnt1", b_if.err_cnt_o, 1);
    drive_b(1'b1, 7, 2);
    tick();
    chk("oor_aloh_y", b_if.y_o, 6'h3f);
    chk("oor_aloh_err", b_if.err_o, 1);
    chk("oor_cnt2", b_if.err_cnt_o, 2);
    drive_b(1'b1, 5, 1);
    tick();
    chk("top_therm_y", b_if.y_o, 6'h3f);
    chk("top_therm_err", b_if.err_o, 0);
    chk("top_therm_cnt", b_if.err_cnt_o, 2);

    // Counter saturation on the 2-bit counter.
    drive_b(1'b0, 0, 0);
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    chk("sat_rst_cnt", b_if.err_cnt_o, 0);
    for (int i = 0; i < 5; i++) begin
      drive_b(1'b1, i, 3);
      tick();
      chk("sat_cnt", b_if.err_cnt_o, (i + 1 > 3) ? 3 : i + 1);
      chk("sat_err", b_if.err_o, 1);
      chk("sat_y", b_if.y_o, 0);
    end
    drive_b(1'b0, 0, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
